// File: rtl/flush_ctrl.sv
// Pipeline flush/redirect controller: arbitrates flush sources by age, drives per-stage squash
// masks, drains an outstanding fetch transaction, then holds a redirect until fetch accepts it.
// Optional performance counters are enabled with `define FLUSH_CTRL_PERF_EN.
module flush_ctrl #(
  parameter int NSRC   = 4,
  parameter int NSTAGE = 5,
  parameter int XLEN   = 64,
  parameter int SW     = $clog2(NSTAGE)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NSRC-1:0]          req_valid,
  input  logic [NSRC*XLEN-1:0]     req_pc,
  input  logic [NSRC*SW-1:0]       req_stage,
  input  logic                     mem_busy,
  input  logic                     redir_ready,
  output logic                     redir_valid,
  output logic [XLEN-1:0]          redir_pc,
  output logic [NSTAGE-1:0]        flush_mask,
  output logic                     stall_fetch,
  output logic                     busy,
`ifdef FLUSH_CTRL_PERF_EN
  output logic [31:0]              perf_flush_cnt,
  output logic [31:0]              perf_drain_cyc,
`endif
  output logic [$clog2(NSRC)-1:0]  cause_src
);

  localparam int CW = $clog2(NSRC);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIR} state_t;

  state_t            state, next_state;
  logic [XLEN-1:0]   cur_pc;
  logic [SW-1:0]     cur_stage;
  logic [CW-1:0]     cur_idx;

  logic              win_valid;
  logic [CW-1:0]     win_idx;
  logic [SW-1:0]     win_stage;
  logic [XLEN-1:0]   win_pc;
  logic [NSTAGE-1:0] win_mask;
  logic              preempt;
  logic              capture;

  // Oldest request wins; strict compare keeps the lowest index on a stage tie.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_stage = '0;
    win_pc    = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (req_valid[i] && (!win_valid || req_stage[i*SW +: SW] > win_stage)) begin
        win_valid = 1'b1;
        win_idx   = CW'(i);
        win_stage = req_stage[i*SW +: SW];
        win_pc    = req_pc[i*XLEN +: XLEN];
      end
    end
    win_mask = '0;
    for (int s = 0; s < NSTAGE; s++) begin
      win_mask[s] = (s < int'(win_stage));
    end
    preempt = (win_stage > cur_stage) || ((win_stage == cur_stage) && (win_idx < cur_idx));
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    flush_mask = '0;
    case (state)
      IDLE: begin
        capture = win_valid;
      end
      DRAIN: begin
        flush_mask[0] = 1'b1;
        if (!mem_busy) next_state = REDIR;
        capture = win_valid && preempt;
      end
      REDIR: begin
        // A completed handshake frees the controller, so any request is taken as fresh.
        if (redir_ready) begin
          next_state = IDLE;
          capture    = win_valid;
        end else begin
          capture = win_valid && preempt;
        end
      end
      default: next_state = IDLE;
    endcase
    if (capture) begin
      flush_mask = flush_mask | win_mask;
      next_state = mem_busy ? DRAIN : REDIR;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cur_pc    <= '0;
      cur_stage <= '0;
      cur_idx   <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        cur_pc    <= win_pc;
        cur_stage <= win_stage;
        cur_idx   <= win_idx;
      end
    end
  end

`ifdef FLUSH_CTRL_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_flush_cnt <= '0;
      perf_drain_cyc <= '0;
    end else begin
      if (capture) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (state == DRAIN) perf_drain_cyc <= perf_drain_cyc + 32'd1;
    end
  end
`endif

  assign busy        = (state != IDLE);
  assign stall_fetch = (state != IDLE);
  assign redir_valid = (state == REDIR);
  assign redir_pc    = cur_pc;
  assign cause_src   = cur_idx;

endmodule

// File: tb/tb_flush_ctrl.sv
// Self-checking bench for flush_ctrl: directed scenarios plus randomized traffic
// compared against a priority-key reference model.
module tb_flush_ctrl;
  localparam int NSRC   = 4;
  localparam int NSTAGE = 5;
  localparam int XLEN   = 64;
  localparam int SW     = 3;
  localparam int CW     = 2;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NSRC-1:0]      req_valid;
  logic [NSRC*XLEN-1:0] req_pc;
  logic [NSRC*SW-1:0]   req_stage;
  logic                 mem_busy;
  logic                 redir_ready;
  logic                 redir_valid;
  logic [XLEN-1:0]      redir_pc;
  logic [NSTAGE-1:0]    flush_mask;
  logic                 stall_fetch;
  logic                 busy;
  logic [CW-1:0]        cause_src;
`ifdef FLUSH_CTRL_PERF_EN
  logic [31:0]          perf_flush_cnt;
  logic [31:0]          perf_drain_cyc;
`endif

  int total = 0;
  int bad   = 0;

  flush_ctrl #(.NSRC(NSRC), .NSTAGE(NSTAGE), .XLEN(XLEN), .SW(SW)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_pc(req_pc),
    .req_stage(req_stage), .mem_busy(mem_busy), .redir_ready(redir_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .flush_mask(flush_mask),
    .stall_fetch(stall_fetch), .busy(busy),
`ifdef FLUSH_CTRL_PERF_EN
    .perf_flush_cnt(perf_flush_cnt), .perf_drain_cyc(perf_drain_cyc),
`endif
    .cause_src(cause_src)
  );

  always #5 clk = ~clk;

  task automatic clear_reqs();
    req_valid = '0;
    req_pc    = '0;
    req_stage = '0;
  endtask

  task automatic set_req(input int i, input logic [XLEN-1:0] pc, input int st);
    req_valid[i]             = 1'b1;
    req_pc[i*XLEN +: XLEN]   = pc;
    req_stage[i*SW +: SW]    = SW'(st);
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_reqs();
    mem_busy    = 1'b0;
    redir_ready = 1'b0;
    resetn      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_reqs();
    mem_busy    = 1'b0;
    redir_ready = 1'b0;
    resetn      = 1'b0;
    #3;
    total++;
    if ({redir_valid, busy, stall_fetch, flush_mask, cause_src} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want 0", {redir_valid, busy, stall_fetch, flush_mask, cause_src});
    end
    total++;
    if (redir_pc !== '0) begin
      bad++;
      $display("[TB] FAIL reset_pc: got %h want 0", redir_pc);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 64'h8000_0100, 4);
    #1;
    total++;
    if ({busy, flush_mask} !== {1'b0, 5'b01111}) begin
      bad++;
      $display("[TB] FAIL single_c0: got busy/mask %b want 001111", {busy, flush_mask});
    end
    next_cycle();
    clear_reqs();
    #1;
    total++;
    if ({redir_valid, redir_pc} !== {1'b1, 64'h8000_0100}) begin
      bad++;
      $display("[TB] FAIL single_c1: got %b %h want 1 8000_0100", redir_valid, redir_pc);
    end
    next_cycle();
    redir_ready = 1'b1;
    #1;
    total++;
    if ({redir_valid, stall_fetch, flush_mask} !== {2'b11, 5'b00000}) begin
      bad++;
      $display("[TB] FAIL single_c2: got %b want 1100000", {redir_valid, stall_fetch, flush_mask});
    end
    next_cycle();
    redir_ready = 1'b0;
    #1;
    total++;
    if ({busy, redir_valid, redir_pc, cause_src} !== {2'b00, 64'h8000_0100, 2'd0}) begin
      bad++;
      $display("[TB] FAIL single_c3: got busy=%b rv=%b pc=%h cause=%0d want 0 0 8000_0100 0", busy, redir_valid, redir_pc, cause_src);
    end
  endtask

  task automatic test_drain();
    do_reset();
    set_req(2, 64'h0000_0abc, 3);
    mem_busy = 1'b1;
    #1;
    total++;
    if (flush_mask !== 5'b00111) begin
      bad++;
      $display("[TB] FAIL drain_entry_mask: got %b want 00111", flush_mask);
    end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      clear_reqs();
      mem_busy = (c < 3);
      #1;
      total++;
      if ({flush_mask, stall_fetch, redir_valid, busy} !== {5'b00001, 3'b101}) begin
        bad++;
        $display("[TB] FAIL drain_cycle%0d: got %b want 00001101", c, {flush_mask, stall_fetch, redir_valid, busy});
      end
    end
    next_cycle();
    #1;
    total++;
    if ({redir_valid, flush_mask, redir_pc, cause_src} !== {1'b1, 5'b00000, 64'h0000_0abc, 2'd2}) begin
      bad++;
      $display("[TB] FAIL drain_redirect: got rv=%b mask=%b pc=%h cause=%0d", redir_valid, flush_mask, redir_pc, cause_src);
    end
`ifdef FLUSH_CTRL_PERF_EN
    total++;
    if ({perf_flush_cnt, perf_drain_cyc} !== {32'd1, 32'd3}) begin
      bad++;
      $display("[TB] FAIL drain_perf: got %0d %0d want 1 3", perf_flush_cnt, perf_drain_cyc);
    end
`endif
  endtask

  task automatic test_arbitration();
    do_reset();
    set_req(1, 64'h111, 2);
    set_req(3, 64'h333, 4);
    #1;
    total++;
    if (flush_mask !== 5'b01111) begin
      bad++;
      $display("[TB] FAIL arb_age_mask: got %b want 01111", flush_mask);
    end
    next_cycle();
    clear_reqs();
    #1;
    total++;
    if ({cause_src, redir_pc} !== {2'd3, 64'h333}) begin
      bad++;
      $display("[TB] FAIL arb_age_winner: got %0d %h want 3 333", cause_src, redir_pc);
    end
    do_reset();
    set_req(0, 64'h100, 3);
    set_req(2, 64'h222, 3);
    #1;
    total++;
    if (flush_mask !== 5'b00111) begin
      bad++;
      $display("[TB] FAIL arb_tie_mask: got %b want 00111", flush_mask);
    end
    next_cycle();
    clear_reqs();
    #1;
    total++;
    if ({cause_src, redir_pc} !== {2'd0, 64'h100}) begin
      bad++;
      $display("[TB] FAIL arb_tie_winner: got %0d %h want 0 100", cause_src, redir_pc);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    set_req(1, 64'h100, 2);
    next_cycle();
    clear_reqs();
    set_req(3, 64'h200, 4);
    #1;
    total++;
    if ({redir_pc, flush_mask} !== {64'h100, 5'b01111}) begin
      bad++;
      $display("[TB] FAIL preempt_mask: got pc=%h mask=%b want 100 01111", redir_pc, flush_mask);
    end
    next_cycle();
    clear_reqs();
    set_req(0, 64'h999, 1);
    #1;
    total++;
    if ({redir_valid, redir_pc, cause_src, flush_mask} !== {1'b1, 64'h200, 2'd3, 5'b00000}) begin
      bad++;
      $display("[TB] FAIL preempt_taken: got rv=%b pc=%h cause=%0d mask=%b", redir_valid, redir_pc, cause_src, flush_mask);
    end
    next_cycle();
    clear_reqs();
    #1;
    total++;
    if ({redir_pc, cause_src} !== {64'h200, 2'd3}) begin
      bad++;
      $display("[TB] FAIL preempt_younger_ignored: got pc=%h cause=%0d want 200 3", redir_pc, cause_src);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(1, 64'h5000, 3);
    next_cycle();
    clear_reqs();
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({redir_valid, redir_pc} !== {1'b1, 64'h5000}) begin
        bad++;
        $display("[TB] FAIL backpressure_hold%0d: got %b %h want 1 5000", c, redir_valid, redir_pc);
      end
      next_cycle();
    end
    redir_ready = 1'b1;
    set_req(2, 64'h300, 1);
    #1;
    total++;
    if ({busy, flush_mask} !== {1'b1, 5'b00001}) begin
      bad++;
      $display("[TB] FAIL b2b_handshake_cycle: got %b want 100001", {busy, flush_mask});
    end
    next_cycle();
    clear_reqs();
    redir_ready = 1'b0;
    #1;
    total++;
    if ({busy, redir_valid, redir_pc, cause_src} !== {2'b11, 64'h300, 2'd2}) begin
      bad++;
      $display("[TB] FAIL b2b_new_redirect: got busy=%b rv=%b pc=%h cause=%0d", busy, redir_valid, redir_pc, cause_src);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    set_req(1, 64'h400, 2);
    mem_busy = 1'b1;
    next_cycle();
    clear_reqs();
    #1;
    total++;
    if ({busy, flush_mask} !== {1'b1, 5'b00001}) begin
      bad++;
      $display("[TB] FAIL midreset_in_drain: got %b want 100001", {busy, flush_mask});
    end
    #1;
    resetn = 1'b0;
    #1;
    total++;
    if ({redir_valid, busy, stall_fetch, flush_mask, cause_src, redir_pc} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got rv=%b busy=%b stall=%b mask=%b cause=%0d pc=%h", redir_valid, busy, stall_fetch, flush_mask, cause_src, redir_pc);
    end
    next_cycle();
    resetn   = 1'b1;
    mem_busy = 1'b0;
    next_cycle();
    #1;
    total++;
    if ({busy, redir_valid} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL midreset_dropped: got busy=%b rv=%b want 0 0", busy, redir_valid);
    end
`ifdef FLUSH_CTRL_PERF_EN
    total++;
    if ({perf_flush_cnt, perf_drain_cyc} !== 64'd0) begin
      bad++;
      $display("[TB] FAIL midreset_perf: got %0d %0d want 0 0", perf_flush_cnt, perf_drain_cyc);
    end
`endif
  endtask

  // Reference model: each request gets a priority key (age first, then low index),
  // a pending redirect is replaced only by a strictly higher key.
  task automatic test_random();
    bit              m_pending  = 0;
    bit              m_draining = 0;
    int              m_key      = 0;
    int              m_idx      = 0;
    logic [XLEN-1:0] m_pc       = '0;
    int              m_flushes  = 0;
    int              m_drains   = 0;
    int              errs_before;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int              best_key, best_i, best_st;
      logic [XLEN-1:0] best_pc;
      bit              hs, take;
      logic [NSTAGE-1:0] exp_mask;
      clear_reqs();
      for (int i = 0; i < NSRC; i++) begin
        if ($urandom_range(0, 3) == 0) set_req(i, {$urandom, $urandom}, $urandom_range(0, NSTAGE-1));
      end
      mem_busy    = ($urandom_range(0, 2) == 0);
      redir_ready = $urandom_range(0, 1);
      #1;
      best_key = -1; best_i = 0; best_st = 0; best_pc = '0;
      for (int i = 0; i < NSRC; i++) begin
        int st, key;
        st  = int'(req_stage[i*SW +: SW]);
        key = st * NSRC + (NSRC - 1 - i);
        if (req_valid[i] && key > best_key) begin
          best_key = key; best_i = i; best_st = st; best_pc = req_pc[i*XLEN +: XLEN];
        end
      end
      hs   = m_pending && !m_draining && redir_ready;
      take = (best_key >= 0) && (!m_pending || hs || best_key > m_key);
      exp_mask = m_draining ? NSTAGE'(1) : '0;
      if (take) exp_mask = exp_mask | NSTAGE'((1 << best_st) - 1);
      errs_before = bad;
      total++;
      if (flush_mask !== exp_mask) begin
        bad++;
        $display("[TB] FAIL rand_mask n=%0d: got %b want %b", n, flush_mask, exp_mask);
      end
      total++;
      if ({busy, stall_fetch, redir_valid} !== {m_pending, m_pending, m_pending && !m_draining}) begin
        bad++;
        $display("[TB] FAIL rand_status n=%0d: got %b want %b", n, {busy, stall_fetch, redir_valid}, {m_pending, m_pending, m_pending && !m_draining});
      end
      total++;
      if ({redir_pc, cause_src} !== {m_pc, CW'(m_idx)}) begin
        bad++;
        $display("[TB] FAIL rand_capture n=%0d: got %h/%0d want %h/%0d", n, redir_pc, cause_src, m_pc, m_idx);
      end
`ifdef FLUSH_CTRL_PERF_EN
      total++;
      if ({perf_flush_cnt, perf_drain_cyc} !== {32'(m_flushes), 32'(m_drains)}) begin
        bad++;
        $display("[TB] FAIL rand_perf n=%0d: got %0d %0d want %0d %0d", n, perf_flush_cnt, perf_drain_cyc, m_flushes, m_drains);
      end
`endif
      if (m_draining) m_drains++;
      if (take) begin
        m_pending  = 1;
        m_draining = mem_busy;
        m_key      = best_key;
        m_idx      = best_i;
        m_pc       = best_pc;
        m_flushes++;
      end else if (hs) begin
        m_pending = 0;
      end else if (m_draining && !mem_busy) begin
        m_draining = 0;
      end
      next_cycle();
      if (bad > errs_before + 20) break;
    end
    clear_reqs();
    mem_busy    = 1'b0;
    redir_ready = 1'b0;
  endtask

  initial begin
    clear_reqs();
    mem_busy    = 1'b0;
    redir_ready = 1'b0;
    resetn      = 1'b1;
    #2;
    test_reset();
    test_single();
    test_drain();
    test_arbitration();
    test_preempt();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
